// File: rtl/tt_mizidd_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tt_mizidd_alu_sequencer
// Purpose  : Program sequencer for the 7-bit accumulator ALU. Stores up to
//            DEPTH {opcode[2:0], operand[6:0]} words loaded over a valid/ready
//            port. On start it replays them, one word per clock, onto the
//            registered ALU opcode/operand outputs. It emits NOP (0,0) whenever
//            it is not running.
// Ports    : clk, rst_n (sync, active low), ena (global freeze when low)
//            wr_valid/wr_ready/wr_opcode/wr_operand : program load port
//            start/loop/stop/clear                  : replay control
//            alu_opcode/alu_operand                 : registered ALU drive
//            count                                  : words stored, 0..DEPTH
//            busy (RUN), done (one-cycle pulse, DONE)
// Revision : 1.0 - initial release
// ============================================================================
module tt_mizidd_alu_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_opcode,
  input  logic [6:0]        wr_operand,
  input  logic              start,
  input  logic              loop,
  input  logic              stop,
  input  logic              clear,
  output logic [2:0]        alu_opcode,
  output logic [6:0]        alu_operand,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ONE   = (ADDR_W + 1)'(1);
  localparam logic [2:0]      c_HALT  = 3'b111;

  state_t          r_state;
  logic [ADDR_W:0] r_count;
  logic [ADDR_W:0] r_pc;
  logic            r_loop;
  logic [2:0]      r_alu_opcode;
  logic [6:0]      r_alu_operand;
  logic            r_busy;
  logic            r_done;
  logic [9:0]      r_mem [DEPTH];

  logic            w_wr_fire;
  logic [9:0]      w_cur_word;
  logic [9:0]      w_first_word;

  // start and clear outrank a write in IDLE, so they withdraw ready outright.
  assign wr_ready     = ena & (r_state == S_IDLE) & (r_count < c_DEPTH) & ~start & ~clear;
  assign w_wr_fire    = wr_valid & wr_ready;
  // Only indexed in RUN while pc < count <= DEPTH, so the low bits suffice.
  assign w_cur_word   = r_mem[r_pc[ADDR_W-1:0]];
  assign w_first_word = r_mem[0];

  assign count        = r_count;
  assign alu_opcode   = r_alu_opcode;
  assign alu_operand  = r_alu_operand;
  assign busy         = r_busy;
  assign done         = r_done;

  // Program storage carries no reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_fire) begin
      r_mem[r_count[ADDR_W-1:0]] <= {wr_opcode, wr_operand};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_pc          <= '0;
      r_loop        <= 1'b0;
      r_alu_opcode  <= '0;
      r_alu_operand <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          r_alu_opcode  <= '0;
          r_alu_operand <= '0;
          r_done        <= 1'b0;
          if (clear) begin
            r_count <= '0;
          end else if (start && (r_count != '0)) begin
            // Word 0 goes out on the start edge itself, unconditionally.
            r_state       <= S_RUN;
            r_busy        <= 1'b1;
            r_loop        <= loop;
            r_alu_opcode  <= w_first_word[9:7];
            r_alu_operand <= w_first_word[6:0];
            r_pc          <= c_ONE;
          end else if (w_wr_fire) begin
            r_count <= r_count + c_ONE;
          end
        end

        S_RUN: begin
          if (stop || ((r_pc == r_count) && !r_loop) ||
              ((r_pc != r_count) && (w_cur_word[9:7] == c_HALT))) begin
            r_alu_opcode  <= '0;
            r_alu_operand <= '0;
            r_state       <= S_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
          end else if (r_pc == r_count) begin
            // Loop wrap: word 0 is re-issued without a HALT check.
            r_alu_opcode  <= w_first_word[9:7];
            r_alu_operand <= w_first_word[6:0];
            r_pc          <= c_ONE;
          end else begin
            r_alu_opcode  <= w_cur_word[9:7];
            r_alu_operand <= w_cur_word[6:0];
            r_pc          <= r_pc + c_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
          r_alu_opcode  <= '0;
          r_alu_operand <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_mizidd_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_mizidd_alu_sequencer
// Purpose  : Self-checking bench for tt_mizidd_alu_sequencer. The reference
//            keeps the loaded program in a queue, expands it into the stream
//            of words a replay should emit, and walks that stream one entry
//            per enabled clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_mizidd_alu_sequencer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_opcode;
  logic [6:0]        wr_operand;
  logic              start;
  logic              loop;
  logic              stop;
  logic              clear;
  logic [2:0]        alu_opcode;
  logic [6:0]        alu_operand;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;

  tt_mizidd_alu_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_opcode  (wr_opcode),
    .wr_operand (wr_operand),
    .start      (start),
    .loop       (loop),
    .stop       (stop),
    .clear      (clear),
    .alu_opcode (alu_opcode),
    .alu_operand(alu_operand),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] prog[$];
  logic [9:0] stream[$];
  logic [9:0] exp_word;
  logic       exp_busy;
  logic       exp_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ena = 1'b1; wr_valid = 1'b0; wr_opcode = '0; wr_operand = '0;
    start = 1'b0; loop = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".op"},   alu_opcode,  exp_word[9:7]);
    chk({tag, ".opnd"}, alu_operand, exp_word[6:0]);
    chk({tag, ".busy"}, busy,        exp_busy);
    chk({tag, ".done"}, done,        exp_done);
  endtask

  // Offer one word in IDLE; it is accepted only when enabled and not full.
  task automatic load(input logic [9:0] w, input logic en);
    wr_valid = 1'b1; wr_opcode = w[9:7]; wr_operand = w[6:0]; ena = en;
    #1 chk("wr_ready", wr_ready, (en && prog.size() < DEPTH));
    tick();
    if (en && prog.size() < DEPTH) prog.push_back(w);
    wr_valid = 1'b0; ena = 1'b1;
    chk("count_load", count, prog.size());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    chk("count_clear", count, 0);
  endtask

  // Words a replay emits: word 0 always, then each following word until a
  // HALT or the end of the program; looping wraps back to word 0.
  task automatic build_stream(input logic lp);
    int p;
    stream.delete();
    stream.push_back(prog[0]);
    p = 1;
    while (stream.size() < 200) begin
      if (p == prog.size()) begin
        if (!lp) break;
        stream.push_back(prog[0]);
        p = 1;
      end else if (prog[p][9:7] == 3'b111) begin
        break;
      end else begin
        stream.push_back(prog[p]);
        p++;
      end
    end
  endtask

  // Start a replay and follow it to IDLE. rnd adds ena gaps, random stops and
  // out-of-state start/clear/write noise; stop_at forces stop on that cycle.
  task automatic run_prog(input logic lp, input logic rnd, input int stop_at);
    int    cur;
    int    cyc;
    logic  running;
    logic  en;
    logic  st;
    build_stream(lp);
    ena = 1'b1; start = 1'b1; loop = lp;
    tick();
    start = 1'b0; wr_valid = 1'b0; loop = 1'b0;
    cur = 0;
    exp_word = stream[0]; exp_busy = 1'b1; exp_done = 1'b0;
    check_outs("run_start");
    running = 1'b1;
    cyc = 0;
    while (running && cyc < 100) begin
      cyc++;
      en = (!rnd || cyc >= 70) ? 1'b1 : ($urandom_range(0, 4) != 0);
      st = (cyc == stop_at) || (cyc >= 70) || (rnd && $urandom_range(0, 15) == 0);
      ena = en; stop = st;
      if (rnd) begin
        start    = ($urandom_range(0, 5) == 0);
        clear    = ($urandom_range(0, 5) == 0);
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_opcode = 3'($urandom); wr_operand = 7'($urandom);
      end
      tick();
      if (en) begin
        if (exp_busy) begin
          if (st || cur + 1 >= stream.size()) begin
            exp_word = '0; exp_busy = 1'b0; exp_done = 1'b1;
          end else begin
            cur++;
            exp_word = stream[cur];
          end
        end else begin
          exp_done = 1'b0;
          running  = 1'b0;
        end
      end
      check_outs("run");
    end
    quiet();
    chk("run_bound", running, 0);
    chk("count_run", count, prog.size());
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    exp_word = '0; exp_busy = 1'b0; exp_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_count", count, 0);
    check_outs("rst");

    // Three-word program replayed with exact per-cycle timing.
    load({3'd1, 7'd5}, 1'b1);
    load({3'd2, 7'd3}, 1'b1);
    load({3'd2, 7'd1}, 1'b1);
    run_prog(1'b0, 1'b0, -1);

    // Reset in the middle of a run aborts immediately.
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    prog.delete();
    exp_word = '0; exp_busy = 1'b0; exp_done = 1'b0;
    chk("rst_mid_count", count, 0);
    check_outs("rst_mid");

    // Fill to DEPTH; a ninth word is refused; clear empties.
    for (int i = 0; i < DEPTH + 1; i++) load(10'($urandom), 1'b1);
    chk("full_count", count, DEPTH);
    do_clear();

    // HALT in word 1 stops the run after word 0.
    load({3'd1, 7'd7}, 1'b1);
    load({3'd7, 7'd0}, 1'b1);
    load({3'd2, 7'd1}, 1'b1);
    run_prog(1'b0, 1'b0, -1);
    do_clear();

    // Looping two-word program, stopped on the sixth cycle.
    load({3'd3, 7'd11}, 1'b1);
    load({3'd4, 7'd22}, 1'b1);
    run_prog(1'b1, 1'b0, 6);

    // start and write on the same edge: run starts, write rejected.
    wr_valid = 1'b1; wr_opcode = 3'd5; wr_operand = 7'd9; start = 1'b1;
    #1 chk("wr_ready_start", wr_ready, 0);
    run_prog(1'b0, 1'b0, -1);
    do_clear();

    // start with an empty program is ignored.
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", busy, 0);
    chk("empty_op", alu_opcode, 0);
    chk("empty_count", count, 0);

    // Randomized programs, loads and runs.
    for (int it = 0; it < 30; it++) begin
      int n;
      do_clear();
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) load(10'($urandom), ($urandom_range(0, 4) != 0));
      if (prog.size() == 0) load(10'($urandom), 1'b1);
      run_prog(1'($urandom), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
